// File: rtl/multimode_counter_if.sv
// Control/status bundle for multimode_counter: reference, control strobes, prescale in; count and status out.
interface multimode_counter_if #(
  parameter int unsigned N = 8,
  parameter int unsigned P = 4
);
  logic [N-1:0] in_input;
  logic         in_latch;
  logic         in_start;
  logic         in_stop;
  logic         in_count_direction;
  logic         in_auto_reload;
  logic [P-1:0] in_prescale;
  logic [N-1:0] out_output;
  logic         out_done;
  logic         out_busy;

  modport master (
    output in_input, in_latch, in_start, in_stop, in_count_direction, in_auto_reload, in_prescale,
    input  out_output, out_done, out_busy
  );

  modport slave (
    input  in_input, in_latch, in_start, in_stop, in_count_direction, in_auto_reload, in_prescale,
    output out_output, out_done, out_busy
  );
endinterface

// File: rtl/multimode_counter.sv
// Up/down timer with latched reference, prescaler, one-shot/auto-reload modes and a one-cycle done pulse.
module multimode_counter #(
  parameter int unsigned N = 8,
  parameter int unsigned P = 4
) (
  input  logic                 in_clk,
  input  logic                 in_nres,
  multimode_counter_if.slave   bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] ref_q,   ref_d;
  logic [P-1:0] pre_q,   pre_d;
  logic         up_q,    up_d;
  logic         auto_q,  auto_d;
  logic         done_q,  done_d;

  logic [N-1:0] term_c;
  logic [N-1:0] start_c;
  logic [N-1:0] step_c;
  logic [N-1:0] cnt_next_c;
  logic         tick_c;

  // Compare values use the reference as it stood before this edge; a latch in RUN applies from the next compare.
  always_comb begin
    term_c     = up_q ? ref_q : '0;
    start_c    = up_q ? '0 : ref_q;
    step_c     = up_q ? (count_q + N'(1)) : (count_q - N'(1));
    cnt_next_c = (count_q == term_c) ? start_c : step_c;
    tick_c     = (pre_q >= bus.in_prescale);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ref_d   = ref_q;
    pre_d   = pre_q;
    up_d    = up_q;
    auto_d  = auto_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        if (bus.in_latch) begin
          ref_d   = bus.in_input;
          count_d = bus.in_count_direction ? '0 : bus.in_input;
        end
        if (bus.in_start && !bus.in_stop) begin
          state_d = ST_RUN;
          up_d    = bus.in_count_direction;
          auto_d  = bus.in_auto_reload;
          count_d = bus.in_count_direction ? '0 : (bus.in_latch ? bus.in_input : ref_q);
        end
      end

      ST_RUN: begin
        if (bus.in_latch) begin
          ref_d = bus.in_input;
        end
        // Stop wins over a tick landing on the same edge.
        if (bus.in_stop) begin
          state_d = ST_IDLE;
          pre_d   = '0;
        end else if (tick_c) begin
          pre_d   = '0;
          count_d = cnt_next_c;
          if (cnt_next_c == term_c) begin
            done_d = 1'b1;
            if (!auto_q) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          pre_d = pre_q + P'(1);
        end
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_nres) begin
    if (!in_nres) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ref_q   <= '0;
      pre_q   <= '0;
      up_q    <= 1'b1;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ref_q   <= ref_d;
      pre_q   <= pre_d;
      up_q    <= up_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_output = count_q;
  assign bus.out_done   = done_q;
  assign bus.out_busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: directed vector table, hand-written corner sequences, random run against a model.
module tb_multimode_counter;

  localparam int unsigned N = 8;
  localparam int unsigned P = 4;

  logic clk;
  logic nres;
  int   n_checks;
  int   n_pass;

  multimode_counter_if #(.N(N), .P(P)) bus ();

  multimode_counter #(.N(N), .P(P)) dut (
    .in_clk  (clk),
    .in_nres (nres),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         latch;
    logic         start;
    logic         stop;
    logic         dir;
    logic         ar;
    logic [P-1:0] pre;
    logic [N-1:0] din;
    logic [N-1:0] exp_out;
    logic         exp_done;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];

  // Reference model state, kept as plain integers.
  bit m_run;
  int m_cnt;
  int m_ref;
  int m_pre;
  bit m_up;
  bit m_ar;
  bit m_done;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic check_all(input string name, input int eo, input int ed, input int eb);
    check({name, ".out"},  int'(bus.out_output), eo);
    check({name, ".done"}, int'(bus.out_done),   ed);
    check({name, ".busy"}, int'(bus.out_busy),   eb);
  endtask

  task automatic drive(input logic l, input logic st, input logic sp, input logic dir,
                       input logic ar, input logic [P-1:0] pr, input logic [N-1:0] d);
    bus.in_latch           = l;
    bus.in_start           = st;
    bus.in_stop            = sp;
    bus.in_count_direction = dir;
    bus.in_auto_reload     = ar;
    bus.in_prescale        = pr;
    bus.in_input           = d;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic l, input logic st, input logic sp, input logic dir,
                              input logic ar, input int pr, input int d,
                              input int eo, input logic ed, input logic eb);
    vec_t v;
    v.latch = l; v.start = st; v.stop = sp; v.dir = dir; v.ar = ar;
    v.pre = P'(pr); v.din = N'(d);
    v.exp_out = N'(eo); v.exp_done = ed; v.exp_busy = eb;
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #3 nres = 1'b0;
    #4 nres = 1'b1;
    #0;
    m_run = 0; m_cnt = 0; m_ref = 0; m_pre = 0; m_up = 1; m_ar = 0; m_done = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int old_ref, term, strt, nxt;
    m_done = 0;
    if (!m_run) begin
      m_pre = 0;
      if (bus.in_latch) begin
        m_ref = int'(bus.in_input);
        m_cnt = bus.in_count_direction ? 0 : m_ref;
      end
      if (bus.in_start && !bus.in_stop) begin
        m_run = 1;
        m_up  = bus.in_count_direction;
        m_ar  = bus.in_auto_reload;
        m_cnt = m_up ? 0 : m_ref;
      end
    end else begin
      old_ref = m_ref;
      if (bus.in_latch) m_ref = int'(bus.in_input);
      if (bus.in_stop) begin
        m_run = 0;
        m_pre = 0;
      end else if (m_pre >= int'(bus.in_prescale)) begin
        m_pre = 0;
        term  = m_up ? old_ref : 0;
        strt  = m_up ? 0 : old_ref;
        if (m_cnt == term) nxt = strt;
        else if (m_up)     nxt = (m_cnt + 1) % 256;
        else               nxt = (m_cnt + 255) % 256;
        m_cnt = nxt;
        if (nxt == term) begin
          m_done = 1;
          if (!m_ar) m_run = 0;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    nres     = 1'b0;
    drive(0, 0, 0, 1, 0, 0, 0);
    #2;
    check_all("reset", 0, 0, 0);
    #10 nres = 1'b1;
    #1;

    // Up one-shot (ref 3, prescale 0), then down auto-reload (ref 2, prescale 2) ending with stop.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3,   0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,   0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,   1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,   2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,   3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,   3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2, 2,   2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2, 0,   2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 0,   1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 2, 0,   1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].latch, vecs[i].start, vecs[i].stop, vecs[i].dir, vecs[i].ar,
            vecs[i].pre, vecs[i].din);
      cycle();
      check_all($sformatf("vec%0d", i), int'(vecs[i].exp_out),
                int'(vecs[i].exp_done), int'(vecs[i].exp_busy));
    end

    // Async reset between edges while running.
    drive(1, 1, 0, 1, 1, 0, 9);
    cycle();
    drive(0, 0, 0, 1, 1, 0, 0);
    cycle();
    cycle();
    check_all("pre_reset", 2, 0, 1);
    #2 nres = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0);
    #2 nres = 1'b1;
    cycle();
    check_all("after_reset", 0, 0, 0);

    // Stop on a tick cycle at count 5, then start+stop together in IDLE.
    drive(1, 1, 0, 1, 0, 0, 9);
    cycle();
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle();
    check_all("count5", 5, 0, 1);
    drive(0, 0, 1, 1, 0, 0, 0);
    cycle();
    check_all("stop_prio", 5, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    cycle();
    check_all("start_stop_idle", 5, 0, 0);

    // Latch 6 at count 2 while running up auto-reload with ref 4.
    drive(1, 1, 0, 1, 1, 0, 4);
    cycle();
    drive(0, 0, 0, 1, 1, 0, 0);
    cycle();
    cycle();
    check_all("latch_run_c2", 2, 0, 1);
    drive(1, 0, 0, 1, 1, 0, 6);
    cycle();
    check_all("latch_run_c3", 3, 0, 1);
    drive(0, 0, 0, 1, 1, 0, 0);
    cycle(); check_all("latch_run_c4", 4, 0, 1);
    cycle(); check_all("latch_run_c5", 5, 0, 1);
    cycle(); check_all("latch_run_c6", 6, 1, 1);
    cycle(); check_all("latch_run_wrap", 0, 0, 1);
    drive(0, 0, 1, 1, 1, 0, 0);
    cycle();

    // Reference 0 auto-reload, direction toggled mid-run, then latch 255 counting down in IDLE.
    drive(1, 1, 0, 1, 1, 0, 0);
    cycle();
    check_all("ref0_start", 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, logic'(i % 2), 1, 0, 0);
      cycle();
      check_all($sformatf("ref0_tick%0d", i), 0, 1, 1);
    end
    drive(0, 0, 1, 0, 1, 0, 0);
    cycle();
    check_all("ref0_stop", 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 255);
    cycle();
    check_all("latch255_down", 255, 0, 0);

    // Randomised run against the model.
    drive(0, 0, 0, 1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)), P'($urandom_range(0, 3)),
            N'($urandom_range(0, 12)));
      model_step();
      cycle();
      check_all($sformatf("rand%0d", i), m_cnt, int'(m_done), int'(m_run));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
